// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the main-memory arbiter.
package mem_arb_pkg;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OFST_W     = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;

  typedef enum logic [1:0] {IDLE, WB, FILL_DC, FILL_IC} state_e;
  typedef enum logic {REQ_IC, REQ_DC} req_id_e;
endpackage

// File: rtl/mem_arb_wb_buf.sv
// Victim-line capture register; presents one word per beat to the memory port.
module mem_arb_wb_buf
  import mem_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic [OFST_W-1:0] i_idx,
  output logic [WORD_W-1:0] o_word
);
  logic [LINE_W-1:0] r_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_line <= '0;
    else if (i_load) r_line <= i_line;
  end

  assign o_word = r_line[i_idx*WORD_W +: WORD_W];
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: DC writeback, DC refill and IC refill as line bursts.
// Optional critical-word-first refills when MEM_ARB_CWF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  input  logic              dc_req,
  input  logic [31:0]       dc_addr,
  input  logic              dc_wb,
  input  logic [31:0]       dc_wb_addr,
  input  logic [LINE_W-1:0] dc_wb_data,
  output logic              ic_valid,
  output logic [WORD_W-1:0] ic_data,
  output logic [OFST_W-1:0] ic_word_idx,
  output logic              ic_done,
  output logic              dc_valid,
  output logic [WORD_W-1:0] dc_data,
  output logic [OFST_W-1:0] dc_word_idx,
  output logic              dc_done,
  output logic              dc_wb_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam int unsigned BASE_W = 32 - OFST_W - 2;

  state_e            r_state;
  req_id_e           r_rr_last;
  logic [BASE_W-1:0] r_base;
  logic [OFST_W-1:0] r_idx;
  logic              r_mem_req;
  logic              r_ic_valid, r_ic_done, r_dc_valid, r_dc_done, r_wb_done;
  logic [WORD_W-1:0] r_ic_data, r_dc_data;
  logic [OFST_W-1:0] r_ic_idx, r_dc_idx;

  logic              w_idle, w_ic_ok, w_dc_ok, w_wb_ok, w_pick_dc;
  logic              w_gnt_wb, w_gnt_dc, w_gnt_ic, w_last;
  logic [OFST_W-1:0] w_start, w_ic_ofst, w_dc_ofst;
  logic              w_unused;

  // A requester whose done pulse is still high has not yet seen completion.
  assign w_ic_ok   = ic_req & ~r_ic_done;
  assign w_dc_ok   = dc_req & ~r_dc_done;
  assign w_wb_ok   = dc_wb  & ~r_wb_done;
  assign w_pick_dc = w_dc_ok & (~w_ic_ok | (r_rr_last == REQ_IC));
  assign w_idle    = (r_state == IDLE);
  assign w_gnt_wb  = w_idle & w_wb_ok;
  assign w_gnt_dc  = w_idle & ~w_wb_ok & w_pick_dc;
  assign w_gnt_ic  = w_idle & ~w_wb_ok & ~w_pick_dc & w_ic_ok;

`ifdef MEM_ARB_CWF_EN
  logic [OFST_W-1:0] r_start;

  assign w_ic_ofst = ic_addr[OFST_W+1:2];
  assign w_dc_ofst = dc_addr[OFST_W+1:2];
  assign w_start   = r_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_start <= '0;
    else if (w_gnt_wb) r_start <= '0;
    else if (w_gnt_dc) r_start <= w_dc_ofst;
    else if (w_gnt_ic) r_start <= w_ic_ofst;
  end
`else
  assign w_ic_ofst = '0;
  assign w_dc_ofst = '0;
  assign w_start   = '0;
`endif

  // The beat index wraps mod LINE_WORDS, so the burst ends when it returns to its start.
  assign w_last   = ((r_idx + OFST_W'(1)) == w_start);
  assign w_unused = ^{ic_addr[4:0], dc_addr[4:0], dc_wb_addr[4:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rr_last  <= REQ_IC;
      r_base     <= '0;
      r_idx      <= '0;
      r_mem_req  <= 1'b0;
      r_ic_valid <= 1'b0;
      r_ic_done  <= 1'b0;
      r_ic_data  <= '0;
      r_ic_idx   <= '0;
      r_dc_valid <= 1'b0;
      r_dc_done  <= 1'b0;
      r_dc_data  <= '0;
      r_dc_idx   <= '0;
      r_wb_done  <= 1'b0;
    end else begin
      r_ic_valid <= 1'b0;
      r_ic_done  <= 1'b0;
      r_dc_valid <= 1'b0;
      r_dc_done  <= 1'b0;
      r_wb_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_wb) begin
            r_state   <= WB;
            r_base    <= dc_wb_addr[31:OFST_W+2];
            r_idx     <= '0;
            r_mem_req <= 1'b1;
          end else if (w_gnt_dc) begin
            r_state   <= FILL_DC;
            r_base    <= dc_addr[31:OFST_W+2];
            r_idx     <= w_dc_ofst;
            r_mem_req <= 1'b1;
          end else if (w_gnt_ic) begin
            r_state   <= FILL_IC;
            r_base    <= ic_addr[31:OFST_W+2];
            r_idx     <= w_ic_ofst;
            r_mem_req <= 1'b1;
          end
        end
        WB: begin
          if (mem_ready) begin
            r_idx <= r_idx + OFST_W'(1);
            if (w_last) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
              r_wb_done <= 1'b1;
            end
          end
        end
        FILL_DC: begin
          if (mem_ready) begin
            r_idx      <= r_idx + OFST_W'(1);
            r_dc_data  <= mem_rdata;
            r_dc_idx   <= r_idx;
            r_dc_valid <= 1'b1;
            if (w_last) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
              r_dc_done <= 1'b1;
              r_rr_last <= REQ_DC;
            end
          end
        end
        FILL_IC: begin
          if (mem_ready) begin
            r_idx      <= r_idx + OFST_W'(1);
            r_ic_data  <= mem_rdata;
            r_ic_idx   <= r_idx;
            r_ic_valid <= 1'b1;
            if (w_last) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
              r_ic_done <= 1'b1;
              r_rr_last <= REQ_IC;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_arb_wb_buf u_wb_buf (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_gnt_wb),
    .i_line  (dc_wb_data),
    .i_idx   (r_idx),
    .o_word  (mem_wdata)
  );

  assign ic_valid    = r_ic_valid;
  assign ic_data     = r_ic_data;
  assign ic_word_idx = r_ic_idx;
  assign ic_done     = r_ic_done;
  assign dc_valid    = r_dc_valid;
  assign dc_data     = r_dc_data;
  assign dc_word_idx = r_dc_idx;
  assign dc_done     = r_dc_done;
  assign dc_wb_done  = r_wb_done;
  assign mem_req     = r_mem_req;
  assign mem_we      = (r_state == WB);
  assign mem_addr    = {r_base, r_idx, 2'b00};
  // The completion-pulse cycle still belongs to the finished transfer.
  assign busy        = ~w_idle | r_ic_done | r_dc_done | r_wb_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req, dc_req, dc_wb;
  logic [31:0]  ic_addr, dc_addr, dc_wb_addr;
  logic [255:0] dc_wb_data;
  logic         ic_valid, ic_done, dc_valid, dc_done, dc_wb_done, busy;
  logic [31:0]  ic_data, dc_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]   ic_word_idx, dc_word_idx;
  logic         mem_req, mem_we, mem_ready;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_addr(dc_addr),
    .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr), .dc_wb_data(dc_wb_data),
    .ic_valid(ic_valid), .ic_data(ic_data), .ic_word_idx(ic_word_idx), .ic_done(ic_done),
    .dc_valid(dc_valid), .dc_data(dc_data), .dc_word_idx(dc_word_idx), .dc_done(dc_done),
    .dc_wb_done(dc_wb_done), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

`ifdef MEM_ARB_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam int K_NONE = 0, K_WB = 1, K_DC = 2, K_IC = 3;

  int checks = 0, errors = 0;

  // Reference model: one outstanding line transfer described by kind/base/start/beats.
  int          m_kind, m_beats, m_start, m_last_fill;
  logic [31:0] m_line;
  logic [31:0] m_wb[8];
  bit          m_icv, m_dcv, m_icd, m_dcd, m_wbd;
  logic [31:0] m_data;
  int          m_idx;

  // Stimulus control and observation logs.
  bit auto_drop = 1'b1, drop_lag = 1'b1;
  bit ic_drop_nx, dc_drop_nx, wb_drop_nx;
  int rdy_mode = 0, rdy_ph = 0, busy_cnt = 0;
  int done_q[$];
  int dcidx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int miss_ofst(input logic [31:0] a);
    return CWF ? int'(a[4:2]) : 0;
  endfunction

  task automatic model_reset();
    m_kind = K_NONE; m_beats = 0; m_start = 0; m_last_fill = K_IC;
    m_icv = 0; m_dcv = 0; m_icd = 0; m_dcd = 0; m_wbd = 0;
  endtask

  task automatic model_edge();
    bit p_icd, p_dcd, p_wbd, ic_ok, dc_ok, wb_ok;
    int w;
    if (!reset) begin model_reset(); return; end
    p_icd = m_icd; p_dcd = m_dcd; p_wbd = m_wbd;
    m_icv = 0; m_dcv = 0; m_icd = 0; m_dcd = 0; m_wbd = 0;
    if (m_kind == K_NONE) begin
      wb_ok = dc_wb && !p_wbd;
      dc_ok = dc_req && !p_dcd;
      ic_ok = ic_req && !p_icd;
      m_beats = 0;
      if (wb_ok) begin
        m_kind = K_WB; m_line = {dc_wb_addr[31:5], 5'b0}; m_start = 0;
        for (int i = 0; i < 8; i++) m_wb[i] = dc_wb_data[32*i +: 32];
      end else if (dc_ok && !(ic_ok && m_last_fill == K_DC)) begin
        m_kind = K_DC; m_line = {dc_addr[31:5], 5'b0}; m_start = miss_ofst(dc_addr);
      end else if (ic_ok) begin
        m_kind = K_IC; m_line = {ic_addr[31:5], 5'b0}; m_start = miss_ofst(ic_addr);
      end
    end else if (mem_ready) begin
      w = (m_start + m_beats) % 8;
      if (m_kind == K_DC) begin m_dcv = 1; m_data = mem_rdata; m_idx = w; end
      if (m_kind == K_IC) begin m_icv = 1; m_data = mem_rdata; m_idx = w; end
      m_beats++;
      if (m_beats == 8) begin
        if (m_kind == K_WB) m_wbd = 1;
        if (m_kind == K_DC) begin m_dcd = 1; m_last_fill = K_DC; end
        if (m_kind == K_IC) begin m_icd = 1; m_last_fill = K_IC; end
        m_kind = K_NONE;
      end
    end
  endtask

  task automatic compare();
    bit busy_e = (m_kind != K_NONE) || m_icd || m_dcd || m_wbd;
    chk("mem_req", mem_req, m_kind != K_NONE);
    if (m_kind != K_NONE) begin
      chk("mem_addr", mem_addr, m_line + 4 * ((m_start + m_beats) % 8));
      chk("mem_we", mem_we, m_kind == K_WB);
      if (m_kind == K_WB) chk("mem_wdata", mem_wdata, m_wb[m_beats]);
    end
    chk("busy", busy, busy_e);
    chk("ic_valid", ic_valid, m_icv);
    chk("ic_done", ic_done, m_icd);
    chk("dc_valid", dc_valid, m_dcv);
    chk("dc_done", dc_done, m_dcd);
    chk("dc_wb_done", dc_wb_done, m_wbd);
    if (m_icv) begin chk("ic_data", ic_data, m_data); chk("ic_word_idx", ic_word_idx, m_idx); end
    if (m_dcv) begin chk("dc_data", dc_data, m_data); chk("dc_word_idx", dc_word_idx, m_idx); end
  endtask

  task automatic drive();
    if (auto_drop) begin
      if (ic_drop_nx) begin ic_req = 0; ic_drop_nx = 0; end
      if (dc_drop_nx) begin dc_req = 0; dc_drop_nx = 0; end
      if (wb_drop_nx) begin dc_wb  = 0; wb_drop_nx = 0; end
      if (ic_done)    begin if (drop_lag) ic_drop_nx = 1; else ic_req = 0; end
      if (dc_done)    begin if (drop_lag) dc_drop_nx = 1; else dc_req = 0; end
      if (dc_wb_done) begin if (drop_lag) wb_drop_nx = 1; else dc_wb  = 0; end
    end
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       begin mem_ready = (rdy_ph % 3 == 0); rdy_ph++; end
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
    mem_rdata = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    if (busy)       busy_cnt++;
    if (dc_wb_done) done_q.push_back(K_WB);
    if (dc_done)    done_q.push_back(K_DC);
    if (ic_done)    done_q.push_back(K_IC);
    if (dc_valid)   dcidx_q.push_back(int'(dc_word_idx));
    drive();
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while ((ic_req || dc_req || dc_wb || m_kind != K_NONE) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, n < max, 1'b1);
    tick();
  endtask

  task automatic rand_line();
    for (int i = 0; i < 8; i++) dc_wb_data[32*i +: 32] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 0; ic_req = 0; dc_req = 0; dc_wb = 0; mem_ready = 0; mem_rdata = '0;
    ic_addr = '0; dc_addr = '0; dc_wb_addr = '0; dc_wb_data = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);   chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);     chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ic_valid", ic_valid, 0); chk("rst_ic_data", ic_data, 0);
    chk("rst_ic_idx", ic_word_idx, 0); chk("rst_ic_done", ic_done, 0);
    chk("rst_dc_valid", dc_valid, 0); chk("rst_dc_data", dc_data, 0);
    chk("rst_dc_idx", dc_word_idx, 0); chk("rst_dc_done", dc_done, 0);
    chk("rst_wb_done", dc_wb_done, 0);
    mem_ready = 1;
    tick(); tick();
    reset = 1;
    tick();

    // Round-robin: both fills held across three transfers, DC wins first tie
    auto_drop = 0; done_q.delete();
    ic_addr = 32'h0000_5000; dc_addr = 32'h0000_6004;
    ic_req = 1; dc_req = 1;
    n = 0;
    while (done_q.size() < 3 && n < 80) begin tick(); n++; end
    ic_req = 0; dc_req = 0; auto_drop = 1;
    chk("rr_timeout", n < 80, 1'b1);
    chk("rr_order0", done_q[0], K_DC);
    chk("rr_order1", done_q[1], K_IC);
    chk("rr_order2", done_q[2], K_DC);
    wait_idle(40, "rr");

    // Single IC fill with ready tied high: busy for 9 cycles
    busy_cnt = 0;
    ic_addr = 32'h0000_1044; ic_req = 1;
    wait_idle(40, "ic1");
    tick(); tick();
    chk("ic1_busy_cycles", busy_cnt, 9);

    // Writeback and DC fill together: writeback first, victim buffered
    done_q.delete();
    dc_wb_addr = 32'h0000_2000;
    for (int i = 0; i < 8; i++) dc_wb_data[32*i +: 32] = 32'h1111_1111 * i;
    dc_addr = 32'h0000_3008; dc_wb = 1; dc_req = 1;
    tick();
    rand_line();
    wait_idle(60, "wb1");
    chk("wb1_order0", done_q[0], K_WB);
    chk("wb1_order1", done_q[1], K_DC);

    // DC fill with ready pattern 1,0,0: stalls hold the address
    dcidx_q.delete(); done_q.delete();
    rdy_mode = 1; rdy_ph = 0;
    dc_addr = $urandom; dc_req = 1;
    wait_idle(80, "stall");
    chk("stall_valid_count", dcidx_q.size(), 8);
    chk("stall_done_count", done_q.size(), 1);
    rdy_mode = 0;

    // Writeback arriving during an IC fill is served before the pending DC fill
    done_q.delete();
    ic_addr = $urandom; ic_req = 1;
    tick(); tick(); tick();
    dc_addr = $urandom; dc_req = 1;
    dc_wb_addr = $urandom; rand_line(); dc_wb = 1;
    wait_idle(80, "wbmid");
    chk("wbmid_order0", done_q[0], K_IC);
    chk("wbmid_order1", done_q[1], K_WB);
    chk("wbmid_order2", done_q[2], K_DC);

    // Miss word at offset 5: critical-word-first when enabled, else from 0
    dcidx_q.delete();
    dc_addr = 32'h0000_4014; dc_req = 1;
    n = 0;
    while (!mem_req && n < 5) begin tick(); n++; end
    chk("cwf_first_addr", mem_addr, CWF ? 32'h0000_4014 : 32'h0000_4000);
    wait_idle(40, "cwf");
    for (int k = 0; k < 8; k++)
      chk("cwf_idx_seq", (k < dcidx_q.size()) ? dcidx_q[k] : -1, ((CWF ? 5 : 0) + k) % 8);

    // Reset at beat 4 of an IC fill: abandoned, then restarts from the start word
    done_q.delete();
    ic_addr = $urandom; ic_req = 1;
    n = 0;
    while (!(m_kind == K_IC && m_beats == 4) && n < 20) begin tick(); n++; end
    chk("rstmid_reach", n < 20, 1'b1);
    reset = 0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_busy", busy, 0);
    model_reset();
    tick(); tick();
    reset = 1;
    chk("rstmid_no_done", done_q.size(), 0);
    wait_idle(40, "rstmid");
    chk("rstmid_one_done", done_q.size(), 1);

    // Random traffic with random ready and random victim data changes
    rdy_mode = 2;
    for (int c = 0; c < 800; c++) begin
      drop_lag = 1'($urandom_range(0, 1));
      if (!ic_req && !ic_drop_nx && $urandom_range(0, 7) == 0) begin ic_addr = $urandom; ic_req = 1; end
      if (!dc_req && !dc_drop_nx && $urandom_range(0, 7) == 0) begin dc_addr = $urandom; dc_req = 1; end
      if (!dc_wb && !wb_drop_nx && $urandom_range(0, 11) == 0) begin
        dc_wb_addr = $urandom; rand_line(); dc_wb = 1;
      end
      if (m_kind == K_WB) rand_line();
      tick();
    end
    wait_idle(400, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
